// File: rtl/nr_div_gen.sv
// Multi-cycle non-restoring divider: one quotient bit per cycle, then a single
// fix-up cycle for remainder restore and sign correction.
module nr_div_gen #(
   parameter int WIDTH     = 32,
   parameter int SIGNED_EN = 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             ctrl_DIV,
   input  logic             ctrl_signed,
   input  logic [WIDTH-1:0] data_operandA,
   input  logic [WIDTH-1:0] data_operandB,
   output logic [WIDTH-1:0] data_quotient,
   output logic [WIDTH-1:0] data_remainder,
   output logic             data_exception,
   output logic             data_resultRDY,
   output logic             busy
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_t;

   state_t           state_reg, state_next;
   logic [WIDTH:0]   a_reg;
   logic [WIDTH-1:0] q_reg, m_reg;
   logic [CW-1:0]    count_reg;
   logic             sign_q_reg, sign_r_reg;

   logic             accept, signed_mode, sign_a, sign_b;
   logic             div_zero, sgn_ovf, special;
   logic [WIDTH-1:0] mag_a, mag_b;
   logic [WIDTH:0]   a_shift, a_step, a_fix;
   logic [WIDTH-1:0] q_step, q_fix, r_fix;

   always_comb begin
      accept      = ctrl_DIV && ((state_reg == IDLE) || (state_reg == DONE));
      signed_mode = (SIGNED_EN != 0) && ctrl_signed;
      sign_a      = signed_mode && data_operandA[WIDTH-1];
      sign_b      = signed_mode && data_operandB[WIDTH-1];
      // -MIN_NEG wraps back to MIN_NEG, which is exactly the unsigned magnitude
      mag_a       = sign_a ? -data_operandA : data_operandA;
      mag_b       = sign_b ? -data_operandB : data_operandB;
      div_zero    = (data_operandB == '0);
      sgn_ovf     = signed_mode && (data_operandA == MIN_NEG) && (data_operandB == '1);
      special     = div_zero || sgn_ovf;
   end

   always_comb begin
      a_shift = {a_reg[WIDTH-1:0], q_reg[WIDTH-1]};
      a_step  = a_reg[WIDTH] ? (a_shift + {1'b0, m_reg}) : (a_shift - {1'b0, m_reg});
      q_step  = {q_reg[WIDTH-2:0], ~a_step[WIDTH]};
      a_fix   = a_reg[WIDTH] ? (a_reg + {1'b0, m_reg}) : a_reg;
      q_fix   = sign_q_reg ? -q_reg : q_reg;
      r_fix   = sign_r_reg ? -a_fix[WIDTH-1:0] : a_fix[WIDTH-1:0];
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // ITER spends one extra cycle at count zero before FIX, giving WIDTH+2 latency
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: begin
            if (accept) state_next = special ? DONE : ITER;
         end
         ITER: begin
            if (count_reg == '0) state_next = FIX;
         end
         FIX: begin
            state_next = DONE;
         end
         DONE: begin
            if (accept) state_next = special ? DONE : ITER;
            else        state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   assign busy           = (state_reg == ITER) || (state_reg == FIX);
   assign data_resultRDY = (state_reg == DONE);

   always_ff @(posedge clock) begin
      if (reset) begin
         a_reg          <= '0;
         q_reg          <= '0;
         m_reg          <= '0;
         count_reg      <= '0;
         sign_q_reg     <= 1'b0;
         sign_r_reg     <= 1'b0;
         data_quotient  <= '0;
         data_remainder <= '0;
         data_exception <= 1'b0;
      end else if (accept) begin
         if (special) begin
            data_quotient  <= div_zero ? '0 : MIN_NEG;
            data_remainder <= div_zero ? data_operandA : '0;
            data_exception <= 1'b1;
         end else begin
            a_reg      <= '0;
            q_reg      <= mag_a;
            m_reg      <= mag_b;
            count_reg  <= CW'(WIDTH);
            sign_q_reg <= sign_a ^ sign_b;
            sign_r_reg <= sign_a;
         end
      end else if ((state_reg == ITER) && (count_reg != '0)) begin
         a_reg     <= a_step;
         q_reg     <= q_step;
         count_reg <= count_reg - 1'b1;
      end else if (state_reg == FIX) begin
         a_reg          <= {r_fix[WIDTH-1], r_fix};
         q_reg          <= q_fix;
         data_quotient  <= q_fix;
         data_remainder <= r_fix;
         data_exception <= 1'b0;
      end
   end

endmodule
